// File: rtl/biu_pkg.sv
// Shared types and constants for the CPLD/ARM bus strobe decoder.
package biu_pkg;

    typedef enum logic [2:0] {
        ST_RELEASE  = 3'd0,
        ST_IDLE     = 3'd1,
        ST_RD_PULSE = 3'd2,
        ST_RD_DATA  = 3'd3,
        ST_RD_HOLD  = 3'd4,
        ST_WR_HOLD  = 3'd5
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_RD_MISS  = 2'b01;
    localparam logic [1:0] ERR_WR_MISS  = 2'b10;
    localparam logic [1:0] ERR_CONFLICT = 2'b11;

    localparam logic [31:0] MISS_VALUE_DEFAULT = 32'hDEADBEEF;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/biu_strobe_decoder_if.sv
// External bus side of the strobe decoder: CPLD strobes, address, channel data and diagnostics.
interface biu_strobe_decoder_if #(
    parameter int unsigned ADDR_W = 24,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NUM_WR = 20,
    parameter int unsigned NUM_RD = 40
);
    logic                     cpld_rs;
    logic                     cpld_ws;
    logic [ADDR_W-1:0]        arm_a;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic                     err_clr;
    logic [NUM_RD-1:0]        rs_vector;
    logic [NUM_WR-1:0]        ws_vector;
    logic [DATA_W-1:0]        arm_data_out;
    logic                     arm_data_oe;
    logic [7:0]               err_count;
    logic [1:0]               err_code;

    modport master (
        output cpld_rs, cpld_ws, arm_a, rd_data, err_clr,
        input  rs_vector, ws_vector, arm_data_out, arm_data_oe, err_count, err_code
    );

    modport slave (
        input  cpld_rs, cpld_ws, arm_a, rd_data, err_clr,
        output rs_vector, ws_vector, arm_data_out, arm_data_oe, err_count, err_code
    );
endinterface

// File: rtl/biu_sync.sv
// Single-bit multi-stage synchroniser; resets to 1 so an idle (high) strobe is assumed.
module biu_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);
    logic [STAGES-1:0] r_stages;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_stages <= '1;
        end else begin
            r_stages <= {r_stages[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_stages[STAGES-1];
endmodule

// File: rtl/biu_strobe_decoder.sv
// Synchronises CPLD strobes, decodes the bus address and emits one active-low
// channel strobe per access, returns read data and logs decode/strobe errors.
module biu_strobe_decoder
    import biu_pkg::*;
#(
    parameter int unsigned       ADDR_W      = 24,
    parameter int unsigned       DATA_W      = 32,
    parameter int unsigned       NUM_WR      = 20,
    parameter int unsigned       NUM_RD      = 40,
    parameter logic [ADDR_W-1:0] WR_BASE     = '0,
    parameter logic [ADDR_W-1:0] RD_BASE     = '0,
    parameter int unsigned       STRIDE_LOG2 = 2,
    parameter int unsigned       SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] MISS_VALUE  = DATA_W'(MISS_VALUE_DEFAULT)
) (
    input logic                 fpga_clk,
    input logic                 rst,
    biu_strobe_decoder_if.slave bus
);
    localparam int unsigned FLUSH_W = $clog2(SYNC_STAGES + 1);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_rs_prev, r_ws_prev;
    logic [FLUSH_W-1:0]  r_flush;
    logic [NUM_RD-1:0]   r_rs_vector;
    logic [NUM_WR-1:0]   r_ws_vector;
    logic [DATA_W-1:0]   r_data_out;
    logic                r_data_oe;
    logic [7:0]          r_err_count;
    logic [1:0]          r_err_code;

    logic                w_s_rs, w_s_ws, w_rs_fall, w_ws_fall;
    logic [ADDR_W-1:0]   w_wr_slot, w_rd_slot;
    logic                w_wr_hit, w_rd_hit;
    logic [NUM_WR-1:0]   w_wr_sel;
    logic [NUM_RD-1:0]   w_rd_sel;
    logic [DATA_W-1:0]   w_rd_word;
    logic                w_conflict, w_wr_miss, w_rd_miss, w_err_any;
    logic [1:0]          w_err_code;

    biu_sync #(.STAGES(SYNC_STAGES)) u_sync_rs (
        .i_clk(fpga_clk), .i_rst(rst), .i_d(bus.cpld_rs), .o_q(w_s_rs)
    );
    biu_sync #(.STAGES(SYNC_STAGES)) u_sync_ws (
        .i_clk(fpga_clk), .i_rst(rst), .i_d(bus.cpld_ws), .o_q(w_s_ws)
    );

    assign w_rs_fall = !w_s_rs && r_rs_prev;
    assign w_ws_fall = !w_s_ws && r_ws_prev;

    // Write decode straight from the bus (used on the fall cycle); read decode from the latched address.
    assign w_wr_slot = (bus.arm_a - WR_BASE) >> STRIDE_LOG2;
    assign w_rd_slot = (r_addr - RD_BASE) >> STRIDE_LOG2;
    assign w_wr_hit  = (bus.arm_a >= WR_BASE) && (w_wr_slot < ADDR_W'(NUM_WR));
    assign w_rd_hit  = (r_addr >= RD_BASE) && (w_rd_slot < ADDR_W'(NUM_RD));

    always_comb begin
        w_wr_sel = '0;
        for (int i = 0; i < NUM_WR; i++) w_wr_sel[i] = (w_wr_slot == ADDR_W'(i));
    end

    always_comb begin
        w_rd_sel  = '0;
        w_rd_word = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            w_rd_sel[i] = (w_rd_slot == ADDR_W'(i));
            if (w_rd_sel[i]) w_rd_word = bus.rd_data[i*DATA_W +: DATA_W];
        end
    end

    assign w_conflict = ((r_state == ST_IDLE) && w_rs_fall && w_ws_fall) ||
                        ((r_state == ST_RD_HOLD) && w_ws_fall) ||
                        ((r_state == ST_WR_HOLD) && w_rs_fall);
    assign w_wr_miss  = (r_state == ST_IDLE) && w_ws_fall && !w_rs_fall && !w_wr_hit;
    assign w_rd_miss  = (r_state == ST_RD_PULSE) && !w_rd_hit;
    assign w_err_any  = w_conflict || w_wr_miss || w_rd_miss;
    assign w_err_code = w_conflict ? ERR_CONFLICT : (w_wr_miss ? ERR_WR_MISS : ERR_RD_MISS);

    // r_flush keeps RELEASE from trusting the reset value of the synchronisers
    // until a real strobe sample has propagated through every stage.
    always_ff @(posedge fpga_clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_RELEASE;
            r_addr      <= '0;
            r_rs_prev   <= 1'b1;
            r_ws_prev   <= 1'b1;
            r_flush     <= FLUSH_W'(SYNC_STAGES);
            r_rs_vector <= '1;
            r_ws_vector <= '1;
            r_data_out  <= '0;
            r_data_oe   <= 1'b0;
        end else begin
            r_rs_prev   <= w_s_rs;
            r_ws_prev   <= w_s_ws;
            r_rs_vector <= '1;
            r_ws_vector <= '1;
            if (r_flush != '0) r_flush <= r_flush - FLUSH_W'(1);
            case (r_state)
                ST_RELEASE: if (r_flush == '0 && w_s_rs && w_s_ws) r_state <= ST_IDLE;
                ST_IDLE: begin
                    if (w_rs_fall && w_ws_fall) begin
                        r_state <= ST_RELEASE;
                    end else if (w_rs_fall) begin
                        r_addr  <= bus.arm_a;
                        r_state <= ST_RD_PULSE;
                    end else if (w_ws_fall) begin
                        r_addr <= bus.arm_a;
                        if (w_wr_hit) r_ws_vector <= ~w_wr_sel;
                        r_state <= ST_WR_HOLD;
                    end
                end
                ST_RD_PULSE: begin
                    if (w_rd_hit) r_rs_vector <= ~w_rd_sel;
                    r_state <= ST_RD_DATA;
                end
                ST_RD_DATA: begin
                    r_data_out <= w_rd_hit ? w_rd_word : MISS_VALUE;
                    r_data_oe  <= 1'b1;
                    r_state    <= ST_RD_HOLD;
                end
                ST_RD_HOLD: begin
                    if (w_s_rs) begin
                        r_data_oe <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                ST_WR_HOLD: if (w_s_ws) r_state <= ST_IDLE;
                default:    r_state <= ST_RELEASE;
            endcase
        end
    end

    // Diagnostic counter: clear wins over increment but still records a coincident error.
    always_ff @(posedge fpga_clk or posedge rst) begin
        if (rst) begin
            r_err_count <= 8'd0;
            r_err_code  <= ERR_NONE;
        end else if (bus.err_clr) begin
            r_err_count <= w_err_any ? 8'd1 : 8'd0;
            r_err_code  <= w_err_any ? w_err_code : ERR_NONE;
        end else if (w_err_any) begin
            r_err_count <= sat_inc8(r_err_count);
            r_err_code  <= w_err_code;
        end
    end

    assign bus.rs_vector    = r_rs_vector;
    assign bus.ws_vector    = r_ws_vector;
    assign bus.arm_data_out = r_data_out;
    assign bus.arm_data_oe  = r_data_oe;
    assign bus.err_count    = r_err_count;
    assign bus.err_code     = r_err_code;
endmodule

// File: doc/biu_strobe_decoder.md
Name: biu_strobe_decoder

Overview:
Parametrised bus-interface strobe decoder between the CPLD/ARM external bus and the on-FPGA peripheral registers (LED drivers, photoresistor/RC channels).
- Synchronises the CPLD read and write strobes.
- Latches and decodes the address once per bus transaction, then emits exactly one active-low single-cycle strobe per access to the selected channel.
- Returns read data with an output enable.
- Counts decode misses and strobe conflicts for software diagnostics.

Parameters:
ADDR_W, 24, width of arm_a
DATA_W, 32, width of read data
NUM_WR, 20, number of write channels
NUM_RD, 40, number of read channels
WR_BASE, 24'h000000, first write-channel address
RD_BASE, 24'h000000, first read-channel address
STRIDE_LOG2, 2, log2 of the byte spacing between channels (4 bytes)
SYNC_STAGES, 2, synchroniser depth (minimum 2)
MISS_VALUE, 32'hDEADBEEF, data returned on a read miss

Ports:
fpga_clk  in  1  system clock, ~100 MHz
rst  in  1  asynchronous, active-high reset
cpld_rs  in  1  read strobe from CPLD, active-low, asynchronous
cpld_ws  in  1  write strobe from CPLD, active-low, asynchronous
arm_a  in  ADDR_W  bus address, stable while either strobe is low
rd_data  in  NUM_RD*DATA_W  channel read data; channel i occupies [i*DATA_W +: DATA_W]
rs_vector  out  NUM_RD  per-channel read pulse, active-low
ws_vector  out  NUM_WR  per-channel write pulse, active-low
arm_data_out  out  DATA_W  read data to the bus tristate
arm_data_oe  out  1  drive enable for arm_data
err_clr  in  1  synchronous clear of the error counter and error code
err_count  out  8  saturating count of errors
err_code  out  2  last error: 00 none, 01 read miss, 10 write miss, 11 conflict

Behaviour:
- Reset values:
  - rs_vector and ws_vector all ones.
  - arm_data_out = 0, arm_data_oe = 0.
  - err_count = 0, err_code = 00.
  - All synchroniser stages = 1.
  - FSM = RELEASE.
- Synchronisers: the synchronised strobes s_rs and s_ws are the final stage of each chain. A fall is s == 0 with the previous sample of s == 1.
- FSM states: RELEASE, IDLE, RD_PULSE, RD_DATA, RD_HOLD, WR_HOLD.
  - RELEASE: leave for IDLE only when s_rs = 1 and s_ws = 1. This prevents a strobe that is already low at reset release from starting a transaction.
  - IDLE, s_rs fall only: latch arm_a, decode, go to RD_PULSE.
  - IDLE, s_ws fall only: latch arm_a and decode. On a hit, drive ws_vector[idx] low for exactly one cycle. Go to WR_HOLD.
  - IDLE, both fall in the same cycle: no pulse, log a conflict, go to RELEASE.
  - RD_PULSE: on a hit, drive rs_vector[idx] low for exactly one cycle. Go to RD_DATA.
  - RD_DATA: capture rd_data[idx] (or MISS_VALUE on a miss) into arm_data_out, set arm_data_oe = 1, go to RD_HOLD.
  - RD_HOLD: when s_rs = 1, clear arm_data_oe and go to IDLE. A fall of s_ws while here logs a conflict and is otherwise ignored.
  - WR_HOLD: when s_ws = 1, go to IDLE. A fall of s_rs while here logs a conflict and is otherwise ignored.
- Latency: from the first fpga_clk edge that samples the strobe low:
  - Strobe pulse is low during the cycle after edge SYNC_STAGES+1 for writes, and after edge SYNC_STAGES+2 for reads.
  - arm_data_oe rises one edge after the read pulse.
- Decode:
  - off = arm_a − BASE, computed in ADDR_W bits.
  - Hit iff arm_a ≥ BASE and (off >> STRIDE_LOG2) < NUM.
  - arm_a < BASE is a miss; there is no wrap-around.
  - Low STRIDE_LOG2 address bits are ignored.
  - A miss produces no pulse and logs 01 (read) or 10 (write).
  - A read miss still completes RD_DATA/RD_HOLD and returns MISS_VALUE.
- Errors:
  - err_count saturates at 255.
  - err_code holds the most recent error.
  - err_clr has priority: an error in the same cycle as err_clr yields err_count = 1 and err_code = that error.
  - Multiple errors in one cycle count once; conflict code wins.
- Each strobe assertion produces at most one channel pulse, regardless of strobe length.
- Reset mid-transaction: all outputs return to reset values immediately, and the FSM waits in RELEASE.

Decomposition:
- Package biu_pkg holds:
  - FSM state enum.
  - err_code constants (ERR_NONE, ERR_RD_MISS, ERR_WR_MISS, ERR_CONFLICT).
  - Default MISS_VALUE.
- Sub-module biu_sync: SYNC_STAGES-deep single-bit synchroniser with reset value 1, instantiated once for each of the two strobes.

Test Plan:
- Write hit: cpld_ws low 20 cycles, arm_a = 24'h000010 → ws_vector = 20'hFFFEF for exactly one cycle, 3 edges after first low sample; no rs pulse; err_count stays 0.
- Read hit: rd_data ch5 = 32'h12345678, arm_a = 24'h000014, cpld_rs low 20 cycles → rs_vector[5] low for one cycle; next edge arm_data_oe = 1 and arm_data_out = 32'h12345678; oe drops after s_rs returns high.
- Misses: write to 24'h000050 (idx 20 ≥ NUM_WR) → no pulse, err_code = 10, err_count = 1. Read at 24'h0000A0 → arm_data_out = 32'hDEADBEEF, err_code = 01, err_count = 2.
- Conflict: cpld_rs and cpld_ws fall on the same cycle → no pulses, err_code = 11. Also: cpld_ws falls during RD_HOLD → conflict logged, read data unaffected.
- Reset with strobe held: cpld_rs low through rst deassertion → no rs pulse until cpld_rs goes high then low again; second fall produces a normal pulse.
- Counter: 300 write misses → err_count = 255. Then err_clr coincident with a miss → err_count = 1, err_code = 10.
